// File: rtl/contador_comparador_param_pkg.sv
// Shared FSM state and MODE encodings for the parametrised counter/comparator.
package cc_pkg;

    typedef enum logic [1:0] {
        CC_IDLE  = 2'd0,
        CC_COUNT = 2'd1,
        CC_DONE  = 2'd2
    } cc_state_t;

    localparam logic CC_FREE    = 1'b0;
    localparam logic CC_ONESHOT = 1'b1;

endpackage

// File: rtl/contador_comparador_param_if.sv
// Control/data bundle of the counter/comparator; UP_DN exists only when CC_DOWN_EN is defined.
interface contador_comparador_param_if #(
    parameter int WIDTH = 4
);
    logic             ENP;
    logic             ENT;
    logic             LD;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] B;
    logic             MODE;
    logic             START;
`ifdef CC_DOWN_EN
    logic             UP_DN;
`endif
    logic [WIDTH-1:0] Q;
    logic             A_maior_que_B;
    logic             A_menor_que_B;
    logic             A_igual_a_B;
    logic             RCO;
    logic             MATCH;
    logic             BUSY;

    modport master (
`ifdef CC_DOWN_EN
        output UP_DN,
`endif
        output ENP, ENT, LD, D, B, MODE, START,
        input  Q, A_maior_que_B, A_menor_que_B, A_igual_a_B, RCO, MATCH, BUSY
    );

    modport slave (
`ifdef CC_DOWN_EN
        input  UP_DN,
`endif
        input  ENP, ENT, LD, D, B, MODE, START,
        output Q, A_maior_que_B, A_menor_que_B, A_igual_a_B, RCO, MATCH, BUSY
    );

endinterface

// File: rtl/contador_comparador_param_comparador_mag.sv
// Unsigned magnitude comparator: exactly one of gt/lt/eq is high.
module comparador_mag #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/contador_comparador_param.sv
// Parametrised modulus counter with magnitude comparator, match pulse and one-shot mode.
// Define CC_DOWN_EN to add the UP_DN port and down-counting.
module contador_comparador_param
    import cc_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int MAX_COUNT   = (1 << WIDTH) - 1,
    parameter int RESET_VALUE = 0
) (
    input  logic                        CLK,
    input  logic                        CLR,
    contador_comparador_param_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_r;
    logic             match_r;
    cc_state_t        state_r;
    logic             up_s;
    logic             count_step_s;
    logic [WIDTH-1:0] nxt_s;
    logic [WIDTH-1:0] load_val_s;
    logic             at_term_s;

    // Count direction: fixed up unless the down-count option is built in.
    always_comb begin
`ifdef CC_DOWN_EN
        up_s = bus.UP_DN;
`else
        up_s = 1'b1;
`endif
    end

    // Next count value with wrap at the terminal in either direction.
    always_comb begin
        nxt_s = q_r;
        if (up_s) begin
            if (q_r == MAX_V) begin
                nxt_s = ZERO_V;
            end else begin
                nxt_s = q_r + ONE_V;
            end
        end else begin
            if (q_r == ZERO_V) begin
                nxt_s = MAX_V;
            end else begin
                nxt_s = q_r - ONE_V;
            end
        end
    end

    // Load value clamped so Q never leaves 0..MAX_COUNT.
    always_comb begin
        if (bus.D > MAX_V) begin
            load_val_s = MAX_V;
        end else begin
            load_val_s = bus.D;
        end
    end

    // A count step needs both enables; in one-shot mode it also needs the FSM in COUNT.
    always_comb begin
        count_step_s = 1'b0;
        if (bus.MODE == CC_ONESHOT) begin
            count_step_s = bus.ENP & bus.ENT & (state_r == CC_COUNT);
        end else begin
            count_step_s = bus.ENP & bus.ENT;
        end
    end

    // Ripple-carry terminal depends on direction.
    always_comb begin
        if (up_s) begin
            at_term_s = (q_r == MAX_V);
        end else begin
            at_term_s = (q_r == ZERO_V);
        end
    end

    // Counter, match pulse and one-shot FSM; load overrides counting and resets the FSM.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            q_r     <= RST_V;
            match_r <= 1'b0;
            state_r <= CC_IDLE;
        end else if (!bus.LD) begin
            q_r     <= load_val_s;
            match_r <= 1'b0;
            state_r <= CC_IDLE;
        end else begin
            if (count_step_s) begin
                q_r <= nxt_s;
            end
            match_r <= count_step_s & (nxt_s == bus.B);
            if (bus.MODE == CC_FREE) begin
                state_r <= CC_IDLE;
            end else begin
                case (state_r)
                    CC_IDLE: begin
                        if (bus.START) begin
                            state_r <= CC_COUNT;
                        end
                    end
                    CC_COUNT: begin
                        if (count_step_s && (nxt_s == bus.B)) begin
                            state_r <= CC_DONE;
                        end
                    end
                    CC_DONE: begin
                        if (bus.START) begin
                            state_r <= CC_COUNT;
                        end
                    end
                    default: state_r <= CC_IDLE;
                endcase
            end
        end
    end

    comparador_mag #(.WIDTH(WIDTH)) u_cmp (
        .a  (q_r),
        .b  (bus.B),
        .gt (bus.A_maior_que_B),
        .lt (bus.A_menor_que_B),
        .eq (bus.A_igual_a_B)
    );

    assign bus.Q     = q_r;
    assign bus.MATCH = match_r;
    assign bus.BUSY  = (state_r == CC_COUNT);
    assign bus.RCO   = bus.ENT & at_term_s;

endmodule

// File: tb/tb_contador_comparador_param.sv
// Scoreboard bench for contador_comparador_param against an arithmetic reference model.
module tb_contador_comparador_param;

    localparam int W = 4;
    localparam int M = 15;

    logic CLK = 1'b0;
    logic CLR;
    always #5 CLK = ~CLK;

    contador_comparador_param_if #(.WIDTH(W)) bus ();
    contador_comparador_param_if #(.WIDTH(W)) bus9 ();

    contador_comparador_param #(.WIDTH(W)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    contador_comparador_param #(.WIDTH(W), .MAX_COUNT(9)) dut9 (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus9)
    );

    typedef struct {
        int   q;
        logic gt, lt, eq, rco, match, busy;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   mq    = 0;
    bit   mrun  = 1'b0;
    logic rmode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every edge the DUT presents a new state, compare it with the oldest expectation.
    always @(posedge CLK) begin
        #1;
        if (sbq.size() != 0) begin
            mon_e = sbq.pop_front();
            chk("q",     32'(bus.Q),         32'(mon_e.q));
            chk("gt",    32'(bus.A_maior_que_B), 32'(mon_e.gt));
            chk("lt",    32'(bus.A_menor_que_B), 32'(mon_e.lt));
            chk("eq",    32'(bus.A_igual_a_B),   32'(mon_e.eq));
            chk("rco",   32'(bus.RCO),       32'(mon_e.rco));
            chk("match", 32'(bus.MATCH),     32'(mon_e.match));
            chk("busy",  32'(bus.BUSY),      32'(mon_e.busy));
        end
    end

    // Apply one cycle of stimulus at the falling edge and push what the next rising edge must show.
    task automatic drive(input logic enp, input logic ent, input logic ld, input logic [3:0] d,
                         input logic [3:0] b, input logic mode, input logic start,
                         input logic up, input bit pulse);
        exp_t e;
        int   nq;
        bit   step;
        @(negedge CLK);
        if (pulse) begin
            CLR = 1'b0;
            #1;
            chk("clr_q",     32'(bus.Q),     32'd0);
            chk("clr_match", 32'(bus.MATCH), 32'd0);
            chk("clr_busy",  32'(bus.BUSY),  32'd0);
            CLR = 1'b1;
            mq   = 0;
            mrun = 1'b0;
            #1;
        end
        bus.ENP = enp; bus.ENT = ent; bus.LD = ld; bus.D = d;
        bus.B = b; bus.MODE = mode; bus.START = start;
`ifdef CC_DOWN_EN
        bus.UP_DN = up;
`else
        up = 1'b1;
`endif
        if (!ld) begin
            mq      = (int'(d) > M) ? M : int'(d);
            mrun    = 1'b0;
            e.match = 1'b0;
        end else begin
            step    = enp && ent && (mode ? mrun : 1'b1);
            nq      = up ? (mq + 1) % (M + 1) : (mq + M) % (M + 1);
            e.match = step && (nq == int'(b));
            if (step) mq = nq;
            if (!mode) mrun = 1'b0;
            else if (mrun) begin
                if (e.match) mrun = 1'b0;
            end else if (start) mrun = 1'b1;
        end
        e.q    = mq;
        e.gt   = mq > int'(b);
        e.lt   = mq < int'(b);
        e.eq   = mq == int'(b);
        e.rco  = ent && (up ? (mq == M) : (mq == 0));
        e.busy = mrun;
        sbq.push_back(e);
    endtask

    task automatic after_edge();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        CLR = 1'b0;
        bus.ENP = 1'b0; bus.ENT = 1'b0; bus.LD = 1'b1; bus.D = 4'd0;
        bus.B = 4'd0; bus.MODE = 1'b0; bus.START = 1'b0;
        bus9.ENP = 1'b0; bus9.ENT = 1'b0; bus9.LD = 1'b1; bus9.D = 4'd0;
        bus9.B = 4'd0; bus9.MODE = 1'b0; bus9.START = 1'b0;
`ifdef CC_DOWN_EN
        bus.UP_DN = 1'b1;
        bus9.UP_DN = 1'b1;
`endif
        #3;
        chk("rst_q",     32'(bus.Q),           32'd0);
        chk("rst_eq",    32'(bus.A_igual_a_B), 32'd1);
        chk("rst_match", 32'(bus.MATCH),       32'd0);
        chk("rst_busy",  32'(bus.BUSY),        32'd0);
        #9;
        CLR = 1'b1;

        // Free-run up to B=5, then one past it; first drive also pulses CLR mid-cycle.
        drive(1'b1, 1'b1, 1'b1, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (4) drive(1'b1, 1'b1, 1'b1, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        after_edge();
        chk("t2_q5",     32'(bus.Q),     32'd5);
        chk("t2_match",  32'(bus.MATCH), 32'd1);
        drive(1'b1, 1'b1, 1'b1, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        after_edge();
        chk("t2_q6",     32'(bus.Q),             32'd6);
        chk("t2_maior",  32'(bus.A_maior_que_B), 32'd1);

        // Enables and RCO gating.
        repeat (2) drive(1'b0, 1'b1, 1'b1, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        after_edge();
        chk("t3_hold", 32'(bus.Q), 32'd6);
        drive(1'b0, 1'b0, 1'b0, 4'd15, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        after_edge();
        chk("t3_rco_off", 32'(bus.RCO), 32'd0);
        drive(1'b0, 1'b1, 1'b1, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        after_edge();
        chk("t3_rco_on", 32'(bus.RCO), 32'd1);
        drive(1'b1, 1'b1, 1'b1, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        after_edge();
        chk("t3_wrap", 32'(bus.Q), 32'd0);

        // One-shot to B=9: one START edge, then 11 more edges.
        drive(1'b1, 1'b1, 1'b1, 4'd0, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (11) drive(1'b1, 1'b1, 1'b1, 4'd0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0);
        after_edge();
        chk("t4_q9",   32'(bus.Q),    32'd9);
        chk("t4_busy", 32'(bus.BUSY), 32'd0);

        // Restart from Q==B, then load during COUNT; clamp on the MAX_COUNT=9 instance.
        drive(1'b1, 1'b1, 1'b1, 4'd0, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) drive(1'b1, 1'b1, 1'b1, 4'd0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 4'd15, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0);
        bus9.LD = 1'b0;
        bus9.D  = 4'd12;
        after_edge();
        chk("t5_q15",   32'(bus.Q),     32'd15);
        chk("t5_busy",  32'(bus.BUSY),  32'd0);
        chk("t5_match", 32'(bus.MATCH), 32'd0);
        chk("t5_clamp", 32'(bus9.Q),    32'd9);
        bus9.LD = 1'b1;

        // Down direction from zero (up-count when the option is absent).
        drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        after_edge();
`ifdef CC_DOWN_EN
        chk("t6_rco_dn", 32'(bus.RCO), 32'd1);
`else
        chk("t6_rco_up", 32'(bus.RCO), 32'd0);
`endif
        drive(1'b1, 1'b1, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        after_edge();
`ifdef CC_DOWN_EN
        chk("t6_q_dn", 32'(bus.Q), 32'd15);
`else
        chk("t6_q_up", 32'(bus.Q), 32'd1);
`endif

        // Randomised traffic with sticky MODE and occasional loads/resets.
        repeat (500) begin
            if ($urandom_range(0, 15) == 0) rmode = ~rmode;
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 19) != 0, 4'($urandom), 4'($urandom_range(0, 15)),
                  rmode, $urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 59) == 0);
        end

        @(posedge CLK);
        #3;
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
